// File: rtl/dac_ramp_scheduler.sv
// Triangle-sweep generator that owns the shared DAC write port, with optional manual one-shot writes.
// Define DAC_RAMP_MANUAL_ARB_EN to enable the manual-write port and its priority arbitration.
module dac_ramp_scheduler #(
  parameter int DAC_DATA_WIDTH = 14,
  parameter int DWELL_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      ch_sel_i,
  input  logic [DAC_DATA_WIDTH-1:0] lo_i,
  input  logic [DAC_DATA_WIDTH-1:0] hi_i,
  input  logic [DAC_DATA_WIDTH-1:0] step_i,
  input  logic [DWELL_WIDTH-1:0]    dwell_i,
  input  logic                      man_req_i,
  input  logic                      man_sel_i,
  input  logic [DAC_DATA_WIDTH-1:0] man_dat_i,
  output logic                      man_ack_o,
  output logic [DAC_DATA_WIDTH-1:0] dac_dat_o,
  output logic                      dac_sel_o,
  output logic                      dac_wrt_o,
  output logic                      busy_o,
  output logic                      dir_o,
  output logic [DWELL_WIDTH-1:0]    tri_cnt_o,
  output logic                      err_o
);

  localparam int AW = DAC_DATA_WIDTH + 1;
  localparam logic [DAC_DATA_WIDTH-1:0] DAC_MID = {1'b1, {(DAC_DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                    state_q;
  logic                      ch_q;
  logic [DAC_DATA_WIDTH-1:0] lo_q;
  logic [DAC_DATA_WIDTH-1:0] hi_q;
  logic [DAC_DATA_WIDTH-1:0] step_q;
  logic [DWELL_WIDTH-1:0]    dwell_q;
  logic [DWELL_WIDTH-1:0]    cnt_q;
  logic [DAC_DATA_WIDTH-1:0] cur_q;
  logic                      dir_q;
  logic [DWELL_WIDTH-1:0]    tri_q;
  logic                      err_q;
  logic                      busy_q;
  logic [DAC_DATA_WIDTH-1:0] dat_q;
  logic                      sel_q;
  logic                      wrt_q;
  logic                      ack_q;

  logic                      man_go_s;
  logic                      man_sel_s;
  logic [DAC_DATA_WIDTH-1:0] man_dat_s;
  logic                      cfg_ok_s;
  logic [AW-1:0]             up_sum_s;
  logic [AW-1:0]             lo_step_s;
  logic [DAC_DATA_WIDTH-1:0] cur_d;
  logic                      dir_d;
  logic [DWELL_WIDTH-1:0]    tri_d;

`ifdef DAC_RAMP_MANUAL_ARB_EN
  logic                      man_pend_q;
  logic                      man_sel_q;
  logic [DAC_DATA_WIDTH-1:0] man_dat_q;

  // A captured request is always served next cycle, so a still-high req is masked while pending.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      man_pend_q <= 1'b0;
      man_sel_q  <= 1'b0;
      man_dat_q  <= DAC_MID;
    end else begin
      man_pend_q <= man_req_i & ~man_pend_q;
      if (man_req_i & ~man_pend_q) begin
        man_sel_q <= man_sel_i;
        man_dat_q <= man_dat_i;
      end
    end
  end

  assign man_go_s  = man_pend_q;
  assign man_sel_s = man_sel_q;
  assign man_dat_s = man_dat_q;
`else
  logic unused_man_s;
  assign unused_man_s = ^{man_req_i, man_sel_i, man_dat_i};
  assign man_go_s  = 1'b0;
  assign man_sel_s = 1'b0;
  assign man_dat_s = DAC_MID;
`endif

  assign cfg_ok_s = (lo_i <= hi_i) && (step_i != {DAC_DATA_WIDTH{1'b0}});

  // Next sweep code, one bit wider than the DAC so the clamp never wraps.
  always_comb begin
    up_sum_s  = {1'b0, cur_q} + {1'b0, step_q};
    lo_step_s = {1'b0, lo_q} + {1'b0, step_q};
    cur_d     = cur_q;
    dir_d     = dir_q;
    tri_d     = tri_q;
    if (!dir_q) begin
      if (up_sum_s >= {1'b0, hi_q}) begin
        cur_d = hi_q;
        dir_d = 1'b1;
      end else begin
        cur_d = up_sum_s[DAC_DATA_WIDTH-1:0];
        dir_d = 1'b0;
      end
    end else begin
      if ({1'b0, cur_q} < lo_step_s) begin
        cur_d = lo_q;
        dir_d = 1'b0;
        tri_d = (&tri_q) ? tri_q : tri_q + DWELL_WIDTH'(1);
      end else begin
        cur_d = cur_q - step_q;
        dir_d = 1'b1;
      end
    end
  end

  // Sweep FSM plus the registered DAC port; a manual write pre-empts the sweep write slot.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ch_q    <= 1'b0;
      lo_q    <= {DAC_DATA_WIDTH{1'b0}};
      hi_q    <= {DAC_DATA_WIDTH{1'b0}};
      step_q  <= {DAC_DATA_WIDTH{1'b0}};
      dwell_q <= {DWELL_WIDTH{1'b0}};
      cnt_q   <= {DWELL_WIDTH{1'b0}};
      cur_q   <= {DAC_DATA_WIDTH{1'b0}};
      dir_q   <= 1'b0;
      tri_q   <= {DWELL_WIDTH{1'b0}};
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      dat_q   <= DAC_MID;
      sel_q   <= 1'b0;
      wrt_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      wrt_q <= man_go_s;
      ack_q <= man_go_s;
      if (man_go_s) begin
        dat_q <= man_dat_s;
        sel_q <= man_sel_s;
      end
      if (stop_i) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              if (cfg_ok_s) begin
                ch_q    <= ch_sel_i;
                lo_q    <= lo_i;
                hi_q    <= hi_i;
                step_q  <= step_i;
                dwell_q <= dwell_i;
                cur_q   <= lo_i;
                dir_q   <= 1'b0;
                tri_q   <= {DWELL_WIDTH{1'b0}};
                err_q   <= 1'b0;
                busy_q  <= 1'b1;
                state_q <= S_WRITE;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_WRITE: begin
            if (!man_go_s) begin
              dat_q <= cur_q;
              sel_q <= ch_q;
              wrt_q <= 1'b1;
              cur_q <= cur_d;
              dir_q <= dir_d;
              tri_q <= tri_d;
              if (dwell_q != {DWELL_WIDTH{1'b0}}) begin
                state_q <= S_HOLD;
                cnt_q   <= dwell_q - DWELL_WIDTH'(1);
              end
            end
          end
          S_HOLD: begin
            if (cnt_q == {DWELL_WIDTH{1'b0}}) begin
              state_q <= S_WRITE;
            end else begin
              cnt_q <= cnt_q - DWELL_WIDTH'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign man_ack_o = ack_q;
  assign dac_dat_o = dat_q;
  assign dac_sel_o = sel_q;
  assign dac_wrt_o = wrt_q;
  assign busy_o    = busy_q;
  assign dir_o     = dir_q;
  assign tri_cnt_o = tri_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_dac_ramp_scheduler.sv
// Scoreboard bench for dac_ramp_scheduler: directed sweeps push expected DAC writes, a monitor pops them.
module tb_dac_ramp_scheduler;
  localparam int W  = 14;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          ch_sel_i = 1'b0;
  logic [W-1:0]  lo_i = '0;
  logic [W-1:0]  hi_i = '0;
  logic [W-1:0]  step_i = '0;
  logic [DW-1:0] dwell_i = '0;
  logic          man_req_i = 1'b0;
  logic          man_sel_i = 1'b0;
  logic [W-1:0]  man_dat_i = '0;
  logic          man_ack_o;
  logic [W-1:0]  dac_dat_o;
  logic          dac_sel_o;
  logic          dac_wrt_o;
  logic          busy_o;
  logic          dir_o;
  logic [DW-1:0] tri_cnt_o;
  logic          err_o;

  typedef struct packed {
    logic [W-1:0]  dat;
    logic          sel;
    logic          ack;
    logic          chk;
    logic          dir;
    logic [DW-1:0] tri_c;
    logic [7:0]    gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_wr = 0;

  dac_ramp_scheduler dut (
    .clk(clk), .rst_i(rst), .start_i(start_i), .stop_i(stop_i), .ch_sel_i(ch_sel_i),
    .lo_i(lo_i), .hi_i(hi_i), .step_i(step_i), .dwell_i(dwell_i),
    .man_req_i(man_req_i), .man_sel_i(man_sel_i), .man_dat_i(man_dat_i), .man_ack_o(man_ack_o),
    .dac_dat_o(dac_dat_o), .dac_sel_o(dac_sel_o), .dac_wrt_o(dac_wrt_o),
    .busy_o(busy_o), .dir_o(dir_o), .tri_cnt_o(tri_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic push(input logic [W-1:0] dat, input logic sel, input logic ack, input logic c,
                      input logic dir, input logic [DW-1:0] tc, input logic [7:0] gap);
    exp_t e;
    e = '{dat: dat, sel: sel, ack: ack, chk: c, dir: dir, tri_c: tc, gap: gap};
    exp_q.push_back(e);
  endtask

  task automatic set_cfg(input logic ch, input logic [W-1:0] lo, input logic [W-1:0] hi,
                         input logic [W-1:0] st, input logic [DW-1:0] dw);
    ch_sel_i = ch; lo_i = lo; hi_i = hi; step_i = st; dwell_i = dw;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    @(posedge clk); #1;
    stop_i = 1'b0;
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (dac_wrt_o) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL unexpected_write: got dat=%0h sel=%0d, expected no write (cycle %0d)",
                 dac_dat_o, dac_sel_o, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_dat", 32'(dac_dat_o), 32'(mon_e.dat));
        chk("wr_sel", 32'(dac_sel_o), 32'(mon_e.sel));
        chk("wr_ack", 32'(man_ack_o), 32'(mon_e.ack));
        if (mon_e.chk) begin
          chk("wr_dir", 32'(dir_o), 32'(mon_e.dir));
          chk("wr_tri", 32'(tri_cnt_o), 32'(mon_e.tri_c));
        end
        if (mon_e.gap != 8'd0) chk("wr_gap", 32'(cyc - last_wr), 32'(mon_e.gap));
      end
      last_wr = cyc;
    end else if (man_ack_o) begin
      chk("ack_without_write", 32'(man_ack_o), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_dat", 32'(dac_dat_o), 32'h2000);
    chk("rst_sel", 32'(dac_sel_o), 32'd0);
    chk("rst_wrt", 32'(dac_wrt_o), 32'd0);
    chk("rst_ack", 32'(man_ack_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_dir", 32'(dir_o), 32'd0);
    chk("rst_tri", 32'(tri_cnt_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("idle_dat", 32'(dac_dat_o), 32'h2000);
    chk("idle_busy", 32'(busy_o), 32'd0);

    // Basic triangle: period 3, channel B, one full triangle plus the restart at lo.
    set_cfg(1'b1, 14'h1000, 14'h1010, 14'h0004, 16'd2);
    push(14'h1000, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0);
    push(14'h1004, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd3);
    push(14'h1008, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd3);
    push(14'h100C, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 8'd3);
    push(14'h1010, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 8'd3);
    push(14'h100C, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 8'd3);
    push(14'h1008, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 8'd3);
    push(14'h1004, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 8'd3);
    push(14'h1000, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 8'd3);
    push(14'h1000, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 8'd3);
    pulse_start();
    chk("start_busy", 32'(busy_o), 32'd1);
    chk("start_no_wrt_yet", 32'(dac_wrt_o), 32'd0);
    @(posedge clk); #1;
    chk("first_wrt_latency", 32'(dac_wrt_o), 32'd1);
    repeat (27) @(posedge clk);
    #1;
    pulse_stop();
    chk("tri_stop_busy", 32'(busy_o), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("tri_drained", 32'(exp_q.size()), 32'd0);
    chk("tri_cnt_hold", 32'(tri_cnt_o), 32'd1);

    // Invalid bounds: rejected, no writes.
    set_cfg(1'b0, 14'h2000, 14'h1000, 14'h0004, 16'd1);
    pulse_start();
    chk("bad_lohi_err", 32'(err_o), 32'd1);
    chk("bad_lohi_busy", 32'(busy_o), 32'd0);
    repeat (10) @(posedge clk);
    #1;

    // lo == hi: direction toggles every write, a triangle every second write; clears err.
    set_cfg(1'b0, 14'h0500, 14'h0500, 14'h0001, 16'd1);
    push(14'h0500, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 8'd0);
    push(14'h0500, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 8'd2);
    push(14'h0500, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 8'd2);
    push(14'h0500, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 8'd2);
    pulse_start();
    chk("valid_clears_err", 32'(err_o), 32'd0);
    repeat (7) @(posedge clk);
    #1;
    pulse_stop();
    repeat (5) @(posedge clk);
    #1;
    chk("lohi_drained", 32'(exp_q.size()), 32'd0);

    // Zero step: rejected.
    set_cfg(1'b0, 14'h0100, 14'h0200, 14'h0000, 16'd1);
    pulse_start();
    chk("bad_step_err", 32'(err_o), 32'd1);
    chk("bad_step_busy", 32'(busy_o), 32'd0);
    repeat (10) @(posedge clk);
    #1;

    // Overshoot clamp near full scale, dwell 0.
    set_cfg(1'b0, 14'h3FF0, 14'h3FFF, 14'h000A, 16'd0);
    push(14'h3FF0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0);
    push(14'h3FFA, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 8'd1);
    push(14'h3FFF, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 8'd1);
    push(14'h3FF5, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 8'd1);
    push(14'h3FF0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 8'd1);
    pulse_start();
    chk("clamp_err", 32'(err_o), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    pulse_stop();
    repeat (5) @(posedge clk);
    #1;
    chk("clamp_drained", 32'(exp_q.size()), 32'd0);

    set_cfg(1'b1, 14'h0100, 14'h0200, 14'h0010, 16'd0);
`ifdef DAC_RAMP_MANUAL_ARB_EN
    // Collision: manual write takes the slot, sweep code slips one cycle.
    push(14'h0100, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0);
    push(14'h0110, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd1);
    push(14'h0123, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 8'd1);
    push(14'h0120, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd1);
    push(14'h0130, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd1);
    push(14'h0140, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd1);
    pulse_start();
    @(posedge clk); #1;
    man_req_i = 1'b1; man_sel_i = 1'b0; man_dat_i = 14'h0123;
    @(posedge clk); #1;
    chk("man_ack_not_early", 32'(man_ack_o), 32'd0);
    @(posedge clk); #1;
    chk("man_ack", 32'(man_ack_o), 32'd1);
    man_req_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`else
    // Manual port disabled: request ignored, sweep untouched.
    push(14'h0100, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0);
    push(14'h0110, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd1);
    push(14'h0120, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd1);
    push(14'h0130, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd1);
    push(14'h0140, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd1);
    pulse_start();
    @(posedge clk); #1;
    man_req_i = 1'b1; man_sel_i = 1'b0; man_dat_i = 14'h0123;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("man_ack_ignored", 32'(man_ack_o), 32'd0);
    man_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`endif
    pulse_stop();
    repeat (5) @(posedge clk);
    #1;
    chk("man_drained", 32'(exp_q.size()), 32'd0);

    // Stop and start together mid-sweep: stop wins, nothing further is written.
    set_cfg(1'b1, 14'h0800, 14'h0900, 14'h0040, 16'd3);
    push(14'h0800, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd0);
    push(14'h0840, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd4);
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    stop_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    stop_i = 1'b0; start_i = 1'b0;
    chk("stopstart_busy", 32'(busy_o), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("stopstart_idle_busy", 32'(busy_o), 32'd0);
    chk("stopstart_drained", 32'(exp_q.size()), 32'd0);

    // Async reset in the middle of a long HOLD.
    set_cfg(1'b1, 14'h0100, 14'h0100, 14'h0001, 16'd5);
    push(14'h0100, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 8'd0);
    pulse_start();
    @(posedge clk);
    @(negedge clk); #1;
    chk("prerst_dir", 32'(dir_o), 32'd1);
    chk("prerst_sel", 32'(dac_sel_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_dat", 32'(dac_dat_o), 32'h2000);
    chk("midrst_sel", 32'(dac_sel_o), 32'd0);
    chk("midrst_wrt", 32'(dac_wrt_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_dir", 32'(dir_o), 32'd0);
    chk("midrst_tri", 32'(tri_cnt_o), 32'd0);
    chk("midrst_err", 32'(err_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("postrst_busy", 32'(busy_o), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_ramp_scheduler.md
# dac_ramp_scheduler

Sequences the shared 14-bit DAC write port of the PDH core: generates a triangle sweep on one DAC channel for lock acquisition (laser/cavity scan) and arbitrates that sweep against one-shot manual writes from the PS command path. Sits between the PS-facing command decoder and the DAC pins (`dac_dat_o`/`dac_sel_o`/`dac_wrt_o`), replacing direct strobe-driven writes. All configuration is latched at sweep start.

## Interface
- `DAC_DATA_WIDTH`, 14, DAC code width (unsigned offset-binary, 0x2000 ≈ 0 V)
- `DWELL_WIDTH`, 16, width of dwell counter and of triangle counter

- `clk`  in  1  system clock; single clock domain
- `rst_i`  in  1  reset, asynchronous, active-high
- `start_i`  in  1  pulse; begin sweep with current config
- `stop_i`  in  1  pulse; abort sweep
- `ch_sel_i`  in  1  channel swept (0 = A, 1 = B)
- `lo_i` / `hi_i`  in  DAC_DATA_WIDTH each  sweep bounds, inclusive
- `step_i`  in  DAC_DATA_WIDTH  code increment per write
- `dwell_i`  in  DWELL_WIDTH  idle cycles between sweep writes
- `man_req_i`  in  1  manual write request (level, held until ack)
- `man_sel_i`  in  1  manual write channel
- `man_dat_i`  in  DAC_DATA_WIDTH  manual write code
- `man_ack_o`  out  1  one-cycle ack; manual write issued same cycle on DAC port
- `dac_dat_o`  out  DAC_DATA_WIDTH  DAC code
- `dac_sel_o`  out  1  DAC channel
- `dac_wrt_o`  out  1  one-cycle write strobe
- `busy_o`  out  1  sweep active
- `dir_o`  out  1  sweep direction (0 up, 1 down)
- `tri_cnt_o`  out  DWELL_WIDTH  completed triangles since start, saturating
- `err_o`  out  1  last start rejected (bad config)

## Operation
- States: IDLE, WRITE, HOLD.
- IDLE: `start_i` with `lo_i <= hi_i` and `step_i != 0` latches ch/lo/hi/step/dwell, sets cur = lo, dir = up, tri_cnt = 0, err = 0, → WRITE. Invalid config: err_o = 1, stay IDLE.
- WRITE: issue sweep write of cur on latched channel, compute next cur, → HOLD if dwell != 0 else stay WRITE.
- HOLD: load counter = dwell on entry, decrement each cycle; at 0 → WRITE. Uncontested write period = dwell + 1 cycles.
- Next-code arithmetic at DAC_DATA_WIDTH+1 bits, no wrap: up: if cur + step >= hi then cur = hi, dir = down; else cur += step. Down: if cur < lo + step then cur = lo, dir = up, tri_cnt++ (saturates at all-ones); else cur -= step.
- lo == hi: every write is lo; dir toggles each write; tri_cnt increments every second write.
- Arbitration: at most one DAC write per cycle. Manual request wins: if `man_req_i` and WRITE coincide, manual write and ack issue; sweep stays in WRITE (cur unchanged) and retries next cycle. Manual writes allowed in any state; HOLD counting is not paused.
- `stop_i`: → IDLE next edge from any state; pending sweep write dropped; cur/dir/tri_cnt hold last values. `stop_i` and `start_i` together: stop wins. `start_i` while busy ignored.
- DAC outputs hold last written code/channel between writes.

## Timing
- All outputs registered. Write decided in cycle N appears on dac_*/man_ack_o after edge N+1 (one cycle after decision).
- start sampled at edge N → state WRITE after N → first `dac_wrt_o` (code lo) high after edge N+1; busy_o high after edge N.
- man_req_i sampled high at edge N (not blocked) → man_ack_o and dac_wrt_o high for exactly one cycle after edge N+1. Requester must deassert on ack; a still-high req the following cycle is a new request.
- Reset (async assert, sync release): dac_dat_o = 0x2000, dac_sel_o = 0, dac_wrt_o = 0, man_ack_o = 0, busy_o = 0, dir_o = 0, tri_cnt_o = 0, err_o = 0, state IDLE. Reset mid-sweep aborts immediately; no write strobe emitted.

## Configuration
- `DAC_RAMP_MANUAL_ARB_EN` defined: manual port and arbitration as above.
- Not defined: man_req_i/man_sel_i/man_dat_i ignored, man_ack_o tied 0, sweep never blocked; DAC port owned solely by the sweep engine.

## Test plan
- Reset then idle: dac_dat_o = 0x2000, all strobes 0, no writes for 100 cycles.
- lo=0x1000, hi=0x1010, step=4, dwell=2, ch=1: write codes 0x1000,1004,…,1010,100C,…,1000 every 3 cycles on sel=1; tri_cnt_o = 1 at return to 0x1000; dir_o flips at 0x1010.
- Overshoot clamp: lo=0x3FF0, hi=0x3FFF, step=0x000A, dwell=0 → codes 0x3FF0,0x3FFA,0x3FFF,0x3FF5,0x3FF0; no wrap past 0x3FFF.
- Collision: dwell=0 sweep running, man_req_i with sel=0, dat=0x0123 → one write 0x0123 sel=0 with man_ack_o, sweep code delayed one cycle, sequence otherwise unchanged.
- Bad config: lo=0x2000, hi=0x1000 (or step=0) → err_o = 1, busy_o = 0, no writes; valid start then clears err_o.
- stop_i and start_i same cycle during sweep, then async reset mid-HOLD → busy_o low next cycle, no further sweep writes; reset forces outputs to reset values immediately.
